// File: rtl/ps_frame_sequencer_pkg.sv
// Shared opcodes, FSM state encoding, reset defaults and payload sizing for the frame sequencer.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package ps_seq_pkg;

  // Header opcodes, carried in header bits [7:4]
  localparam logic [3:0] OP_DATA       = 4'h1;
  localparam logic [3:0] OP_THRESH     = 4'h2;
  localparam logic [3:0] OP_CLASS      = 4'h3;
  localparam logic [3:0] OP_TIMEOUT    = 4'h4;
  localparam logic [3:0] OP_THRESH_ALL = 4'h5;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    COMMIT,
    SEND
  } state_t;

  // Configuration values loaded at reset
  localparam int DEF_THRESH_VAL   = 200;
  localparam int DEF_CLASS_A_VAL  = 20;
  localparam int DEF_CLASS_B_VAL  = 40;
  localparam int DEF_TIMEOUT_VAL  = 100;
  localparam int IDLE_TIMEOUT_VAL = 255;

  // Payload byte count for an opcode; zero marks an unsupported opcode
  function automatic int payload_len(input logic [3:0] op, input int frame_bytes);
    case (op)
      OP_DATA, OP_THRESH:                  return frame_bytes;
      OP_CLASS, OP_TIMEOUT, OP_THRESH_ALL: return 2;
      default:                             return 0;
    endcase
  endfunction

  function automatic logic op_valid(input logic [3:0] op);
    return payload_len(op, 1) != 0;
  endfunction

endpackage

// File: rtl/ps_frame_sequencer_if.sv
// Byte-stream input and frame-stream output bundle of the frame sequencer.
// Latency: n/a (wiring only).
// Backpressure: byte stream stalls on byte_ready low; frame stream holds until data_ready.
interface ps_frame_sequencer_if #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 16
);
  logic [7:0]                  byte_in;
  logic                        byte_valid;
  logic                        byte_ready;
  logic [NUM_UNITS*DATA_W-1:0] data_out;
  logic                        data_valid;
  logic                        data_ready;

  // Sequencer side: consumes bytes, produces frames
  modport master (
    input  byte_in, byte_valid, data_ready,
    output byte_ready, data_out, data_valid
  );

  // Environment side: pad logic sends bytes, datapath accepts frames
  modport slave (
    output byte_in, byte_valid, data_ready,
    input  byte_ready, data_out, data_valid
  );
endinterface

// File: rtl/ps_frame_sequencer_byte_accumulator.sv
// Little-endian shadow register: payload byte k lands in bits [8k+7:8k]; counts accepted bytes.
// Latency: byte visible in o_shadow one cycle after i_shift_en; o_last_byte is combinational.
// Backpressure: none; the parent only asserts i_shift_en on an accepted byte.
module ps_byte_accumulator #(
  parameter int NBYTES = 8,
  parameter int CNT_W  = $clog2(NBYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_shift_en,
  input  logic [7:0]            i_byte,
  input  logic [CNT_W-1:0]      i_len,
  output logic [NBYTES*8-1:0]   o_shadow,
  output logic                  o_last_byte
);

  logic [CNT_W-1:0]    r_cnt;
  logic [NBYTES*8-1:0] r_shadow;

  // Clear on a new header; otherwise drop each accepted byte into its lane and advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (i_clear) begin
      r_cnt    <= '0;
      r_shadow <= '0;
    end else if (i_shift_en) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (r_cnt == CNT_W'(k)) r_shadow[8*k +: 8] <= i_byte;
      end
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_shadow    = r_shadow;
  // True while the byte being offered is the final one of the payload
  assign o_last_byte = (r_cnt == i_len - CNT_W'(1));

endmodule

// File: rtl/ps_frame_sequencer.sv
// Parses header+payload byte packets into sample frames and atomically committed config words.
// Latency: last payload byte -> COMMIT cycle -> frame valid / config updated on the following edge.
// Backpressure: byte_ready drops during COMMIT and while a frame waits for data_ready.
module ps_frame_sequencer
  import ps_seq_pkg::*;
#(
  parameter int NUM_UNITS    = 4,
  parameter int DATA_W       = 16,
  parameter int DEF_THRESH   = DEF_THRESH_VAL,
  parameter int DEF_CLASS_A  = DEF_CLASS_A_VAL,
  parameter int DEF_CLASS_B  = DEF_CLASS_B_VAL,
  parameter int DEF_TIMEOUT  = DEF_TIMEOUT_VAL,
  parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_VAL
) (
  input  logic                        clk,
  input  logic                        rst,
  ps_frame_sequencer_if.master        bus,
  output logic [NUM_UNITS*DATA_W-1:0] threshold_array,
  output logic [7:0]                  class_a_thresh,
  output logic [7:0]                  class_b_thresh,
  output logic [15:0]                 timeout_period,
  output logic                        cfg_update,
  output logic                        err,
  output logic [7:0]                  frame_count
);

  localparam int FRAME_W     = NUM_UNITS * DATA_W;
  localparam int FRAME_BYTES = FRAME_W / 8;
  localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
  localparam logic [DATA_W-1:0]  DEF_LANE         = DATA_W'(DEF_THRESH);
  localparam logic [FRAME_W-1:0] DEF_THRESH_ARRAY = {NUM_UNITS{DEF_LANE}};

  state_t               r_state;
  logic [3:0]           r_opcode;
  logic [CNT_W-1:0]     r_len;
  logic [7:0]           r_idle_cnt;
  logic                 r_byte_ready;
  logic [FRAME_W-1:0]   r_data_out;
  logic                 r_data_valid;
  logic [FRAME_W-1:0]   r_thresh;
  logic [7:0]           r_class_a;
  logic [7:0]           r_class_b;
  logic [15:0]          r_timeout;
  logic                 r_cfg_update;
  logic                 r_err;
  logic [7:0]           r_frame_count;

  logic                 w_byte_acc;
  logic                 w_hdr_acc;
  logic                 w_pay_acc;
  logic [3:0]           w_hdr_op;
  logic [FRAME_W-1:0]   w_shadow;
  logic                 w_last_byte;

  assign w_byte_acc = bus.byte_valid && r_byte_ready;
  assign w_hdr_acc  = w_byte_acc && (r_state == IDLE);
  assign w_pay_acc  = w_byte_acc && (r_state == PAYLOAD);
  assign w_hdr_op   = bus.byte_in[7:4];

  ps_byte_accumulator #(
    .NBYTES (FRAME_BYTES),
    .CNT_W  (CNT_W)
  ) u_acc (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_hdr_acc),
    .i_shift_en  (w_pay_acc),
    .i_byte      (bus.byte_in),
    .i_len       (r_len),
    .o_shadow    (w_shadow),
    .o_last_byte (w_last_byte)
  );

  // Packet FSM with registered handshake, frame, config and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_opcode      <= '0;
      r_len         <= '0;
      r_idle_cnt    <= '0;
      r_byte_ready  <= 1'b1;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_thresh      <= DEF_THRESH_ARRAY;
      r_class_a     <= 8'(DEF_CLASS_A);
      r_class_b     <= 8'(DEF_CLASS_B);
      r_timeout     <= 16'(DEF_TIMEOUT);
      r_cfg_update  <= 1'b0;
      r_err         <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_cfg_update <= 1'b0;
      r_err        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hdr_acc) begin
            if (op_valid(w_hdr_op)) begin
              r_opcode   <= w_hdr_op;
              r_len      <= CNT_W'(payload_len(w_hdr_op, FRAME_BYTES));
              r_idle_cnt <= '0;
              r_state    <= PAYLOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (w_pay_acc) begin
            r_idle_cnt <= '0;
            if (w_last_byte) begin
              r_state      <= COMMIT;
              r_byte_ready <= 1'b0;
            end
          end else if (r_idle_cnt == 8'(IDLE_TIMEOUT - 1)) begin
            // Sender went quiet: abandon the partial packet, shadow is never committed
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 8'd1;
          end
        end
        COMMIT: begin
          if (r_opcode == OP_DATA) begin
            r_data_out   <= w_shadow;
            r_data_valid <= 1'b1;
            r_state      <= SEND;
          end else begin
            case (r_opcode)
              OP_THRESH:     r_thresh  <= w_shadow;
              OP_CLASS: begin
                r_class_a <= w_shadow[7:0];
                r_class_b <= w_shadow[15:8];
              end
              OP_TIMEOUT:    r_timeout <= w_shadow[15:0];
              OP_THRESH_ALL: r_thresh  <= {NUM_UNITS{w_shadow[DATA_W-1:0]}};
              default:       r_thresh  <= r_thresh;
            endcase
            r_cfg_update <= 1'b1;
            r_state      <= IDLE;
            r_byte_ready <= 1'b1;
          end
        end
        SEND: begin
          if (r_data_valid && bus.data_ready) begin
            r_data_valid  <= 1'b0;
            r_frame_count <= r_frame_count + 8'd1;
            r_state       <= IDLE;
            r_byte_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_byte_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready  = r_byte_ready;
  assign bus.data_out    = r_data_out;
  assign bus.data_valid  = r_data_valid;
  assign threshold_array = r_thresh;
  assign class_a_thresh  = r_class_a;
  assign class_b_thresh  = r_class_b;
  assign timeout_period  = r_timeout;
  assign cfg_update      = r_cfg_update;
  assign err             = r_err;
  assign frame_count     = r_frame_count;

endmodule
